// File: rtl/kr_pkg.sv
// -----------------------------------------------------------------------------
// kr_pkg
//
// Shared types and helpers for the Knight Rider LED scanner.
//   kr_mode_e  : scan mode as driven on mode_i
//   kr_pos_w() : width of the head-position index for a given LED count
//   onehot()   : LED mask for a single index, zero when the index is out of range
// -----------------------------------------------------------------------------
package kr_pkg;

    typedef enum logic [1:0] {
        KR_BOUNCE    = 2'd0,
        KR_RING_UP   = 2'd1,
        KR_RING_DOWN = 2'd2,
        KR_HOLD      = 2'd3
    } kr_mode_e;

    // Widest LED bank the scanner supports; onehot() returns this many bits.
    localparam int KR_MAX_WIDTH = 64;

    // Position index width; a 2-LED bank still needs one bit.
    function automatic int kr_pos_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    function automatic logic [KR_MAX_WIDTH-1:0] onehot(input int unsigned idx,
                                                       input int unsigned width);
        return (idx < width) ? (64'd1 << idx) : '0;
    endfunction

endpackage

// File: rtl/kr_prescaler.sv
// -----------------------------------------------------------------------------
// kr_prescaler
//
// Programmable step-rate divider. Produces one tick every div_i+1 enabled
// clocks. The compare is ">=" so that lowering div_i below the running count
// fires on the next enabled cycle instead of wrapping through 2^DIV_W.
//
// Ports:
//   clk_i      system clock
//   sys_rst_i  asynchronous active-low reset (count returns to 0)
//   en_i       count enable; low holds the count and suppresses the tick
//   div_i      compare value
//   tick_o     combinational tick, high in the cycle whose edge commits a step
// -----------------------------------------------------------------------------
module kr_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             hit;

    assign hit    = (cnt_q >= div_i);
    assign tick_o = en_i & hit;

    always_ff @(posedge clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= hit ? '0 : cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/knight_rider_scanner.sv
// -----------------------------------------------------------------------------
// knight_rider_scanner
//
// Parametrised Knight Rider LED scanner: a head LED sweeps the bank in one of
// four runtime-selectable modes, followed by a TAIL-deep trail of its previous
// positions. Step rate comes from the integrated kr_prescaler.
//
// Optional build macro: KR_DWELL_EN -- in BOUNCE mode the head pauses for DWELL
// extra steps at each end before reversing (history keeps shifting, so the
// tail collapses into the head). Without the macro the reversal is immediate
// and no dwell counter exists.
//
// Ports:
//   clk_i      system clock
//   sys_rst_i  asynchronous active-low reset
//   en_i       run enable; low freezes prescaler and scan state
//   mode_i     0=BOUNCE 1=RING_UP 2=RING_DOWN 3=HOLD, sampled on each step
//   div_i      prescaler compare; step period is div_i+1 clocks
//   led_o      head plus tail LED pattern
//   pos_o      head index (scan state, observable)
//   dir_o      1 = head moving toward the MSB (scan state, observable)
//   step_o     one-cycle pulse in the first cycle of each new step
//   wrap_o     one-cycle pulse, coincident with step_o, on a reversal or wrap
//
// Output protocol: step_o is a pure qualifier pulse with no back-pressure.
// In the cycle step_o is high, pos_o/dir_o/led_o/wrap_o all show the new step
// together; wrap_o is never high without step_o. All outputs are flops.
// -----------------------------------------------------------------------------
module knight_rider_scanner
    import kr_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIV_W = 24,
    parameter  int TAIL  = 2,
    parameter  int DWELL = 2,
    localparam int PW    = kr_pos_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    output logic [WIDTH-1:0] led_o,
    output logic [PW-1:0]    pos_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             wrap_o
);

    // Elaboration-time parameter range checks.
    if (WIDTH < 2 || WIDTH > KR_MAX_WIDTH) begin : g_bad_width
        $error("knight_rider_scanner: WIDTH must be 2..64");
    end
    if (TAIL < 0 || TAIL > WIDTH - 1) begin : g_bad_tail
        $error("knight_rider_scanner: TAIL must be 0..WIDTH-1");
    end
    if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
        $error("knight_rider_scanner: DWELL must be 1..15");
    end

    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    localparam logic [PW-1:0] POS_ONE = PW'(1);

    kr_mode_e         mode;
    logic             tick;
    logic [PW-1:0]    pos_q, pos_n;
    logic             dir_q, dir_n;
    logic             wrap_q, wrap_n;
    logic             step_q;
    logic             shift_n;
    logic             at_end;
    logic [WIDTH-1:0] led_q, led_n;
    logic [WIDTH-1:0] tail_n;

    assign mode = kr_mode_e'(mode_i);

    kr_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk_i     (clk_i),
        .sys_rst_i (sys_rst_i),
        .en_i      (en_i),
        .div_i     (div_i),
        .tick_o    (tick)
    );

    // Heading into an end LED in BOUNCE: this step reverses (or dwells first).
    assign at_end = (dir_q && pos_q == POS_MAX) || (!dir_q && pos_q == '0);

`ifdef KR_DWELL_EN
    localparam logic [3:0] DWELL_CNT = 4'(DWELL);

    kr_mode_e   mode_q;
    logic [3:0] dwell_q, dwell_n, dwell_eff;

    // A mode change in progress discards any partially served dwell.
    assign dwell_eff = (mode != mode_q) ? 4'd0 : dwell_q;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            pos_q   <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            led_q   <= WIDTH'(1);
`ifdef KR_DWELL_EN
            mode_q  <= KR_BOUNCE;
            dwell_q <= 4'd0;
`endif
        end else begin
            pos_q   <= pos_n;
            dir_q   <= dir_n;
            step_q  <= tick;
            wrap_q  <= wrap_n;
            led_q   <= led_n;
`ifdef KR_DWELL_EN
            mode_q  <= mode;
            dwell_q <= dwell_n;
`endif
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        pos_n   = pos_q;
        dir_n   = dir_q;
        wrap_n  = 1'b0;
        shift_n = 1'b0;
`ifdef KR_DWELL_EN
        dwell_n = dwell_eff;
`endif
        if (tick) begin
            unique case (mode)
                KR_BOUNCE: begin
                    shift_n = 1'b1;
`ifdef KR_DWELL_EN
                    if (at_end && dwell_eff < DWELL_CNT) begin
                        dwell_n = dwell_eff + 4'd1;
                    end else if (at_end) begin
                        dwell_n = 4'd0;
                        dir_n   = !dir_q;
                        pos_n   = dir_q ? POS_MAX - POS_ONE : POS_ONE;
                        wrap_n  = 1'b1;
                    end else begin
                        pos_n = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
                    end
`else
                    if (at_end) begin
                        dir_n  = !dir_q;
                        pos_n  = dir_q ? POS_MAX - POS_ONE : POS_ONE;
                        wrap_n = 1'b1;
                    end else begin
                        pos_n = dir_q ? pos_q + POS_ONE : pos_q - POS_ONE;
                    end
`endif
                end
                KR_RING_UP: begin
                    shift_n = 1'b1;
                    dir_n   = 1'b1;
                    if (pos_q == POS_MAX) begin
                        pos_n  = '0;
                        wrap_n = 1'b1;
                    end else begin
                        pos_n = pos_q + POS_ONE;
                    end
                end
                KR_RING_DOWN: begin
                    shift_n = 1'b1;
                    dir_n   = 1'b0;
                    if (pos_q == '0) begin
                        pos_n  = POS_MAX;
                        wrap_n = 1'b1;
                    end else begin
                        pos_n = pos_q - POS_ONE;
                    end
                end
                KR_HOLD: begin
                    // Step is still reported; scan state and history freeze.
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------- history
    if (TAIL > 0) begin : g_hist
        logic [PW-1:0] hist_q [TAIL];
        logic [PW-1:0] hist_n [TAIL];

        always_comb begin
            hist_n = hist_q;
            if (shift_n) begin
                hist_n[0] = pos_q;
                for (int k = 1; k < TAIL; k++) begin
                    hist_n[k] = hist_q[k-1];
                end
            end
            tail_n = '0;
            for (int k = 0; k < TAIL; k++) begin
                tail_n = tail_n | WIDTH'(onehot(32'(hist_n[k]), WIDTH));
            end
        end

        always_ff @(posedge clk_i or negedge sys_rst_i) begin
            if (!sys_rst_i) begin
                for (int k = 0; k < TAIL; k++) begin
                    hist_q[k] <= '0;
                end
            end else begin
                hist_q <= hist_n;
            end
        end
    end else begin : g_no_hist
        assign tail_n = '0;
    end

    // --------------------------------------------------------------- output
    // LED image of the next state; registered so led_o changes with pos_o.
    always_comb begin
        led_n = WIDTH'(onehot(32'(pos_n), WIDTH)) | tail_n;
    end

    assign led_o  = led_q;
    assign pos_o  = pos_q;
    assign dir_o  = dir_q;
    assign step_o = step_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_knight_rider_scanner.sv
// -----------------------------------------------------------------------------
// tb_knight_rider_scanner
//
// Directed bench for knight_rider_scanner (WIDTH=8). A TAIL=2 instance and a
// TAIL=0 instance share all inputs. The driver pushes the hand-computed
// expected result of each step into exp_q; the monitor pops one entry per
// step_o pulse and compares. Timing, freeze and reset checks run in the driver.
// -----------------------------------------------------------------------------
module tb_knight_rider_scanner;
    import kr_pkg::*;

    // ------------------------------------------------------ clock and reset
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic [23:0] div   = '0;

    always #5 clk = ~clk;

    logic [7:0] led,  led0;
    logic [2:0] pos,  pos0;
    logic       dir,  dir0;
    logic       step, step0;
    logic       wrap, wrap0;

    knight_rider_scanner #(.WIDTH(8), .DIV_W(24), .TAIL(2), .DWELL(2)) dut (
        .clk_i(clk), .sys_rst_i(rst_n), .en_i(en), .mode_i(mode), .div_i(div),
        .led_o(led), .pos_o(pos), .dir_o(dir), .step_o(step), .wrap_o(wrap)
    );

    knight_rider_scanner #(.WIDTH(8), .DIV_W(24), .TAIL(0), .DWELL(2)) dut_t0 (
        .clk_i(clk), .sys_rst_i(rst_n), .en_i(en), .mode_i(mode), .div_i(div),
        .led_o(led0), .pos_o(pos0), .dir_o(dir0), .step_o(step0), .wrap_o(wrap0)
    );

    // ----------------------------------------------------------- scoreboard
    typedef struct packed {
        logic [2:0] pos;
        logic       dir;
        logic [7:0] led;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push(input logic [2:0] p, input logic d, input logic [7:0] l, input logic w);
        exp_q.push_back('{pos: p, dir: d, led: l, wrap: w});
    endtask

    // Monitor: one expected entry per step pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (step) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_step");
                end else begin
                    e = exp_q.pop_front();
                    check("pos",       32'(pos),   32'(e.pos));
                    check("dir",       32'(dir),   32'(e.dir));
                    check("led",       32'(led),   32'(e.led));
                    check("wrap",      32'(wrap),  32'(e.wrap));
                    check("t0_step",   32'(step0), 32'd1);
                    check("t0_pos",    32'(pos0),  32'(e.pos));
                    check("t0_dir",    32'(dir0),  32'(e.dir));
                    check("t0_wrap",   32'(wrap0), 32'(e.wrap));
                    check("t0_led",    32'(led0),  32'(8'd1) << e.pos);
                end
            end else begin
                check("quiet_cycle", {29'd0, wrap, wrap0, step0}, 32'd0);
            end
        end
    end

    // --------------------------------------------------------------- driver
    task automatic wait_step(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!step && c < 40);
        if (!step) fail("step_timeout");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pos"},  32'(pos),  32'd0);
        check({tag, "_dir"},  32'(dir),  32'd1);
        check({tag, "_led"},  32'(led),  32'h01);
        check({tag, "_led0"}, 32'(led0), 32'h01);
        check({tag, "_step"}, 32'(step), 32'd0);
        check({tag, "_wrap"}, 32'(wrap), 32'd0);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        int c;
        int c2;
        int n1;

        // Reset state.
        @(negedge clk);
        check_reset_values("reset");

        // Full bounce sweep at one step per clock.
`ifdef KR_DWELL_EN
        n1 = 19;
        push(1,1,8'h03,0); push(2,1,8'h07,0); push(3,1,8'h0E,0); push(4,1,8'h1C,0);
        push(5,1,8'h38,0); push(6,1,8'h70,0); push(7,1,8'hE0,0);
        push(7,1,8'hC0,0); push(7,1,8'h80,0);
        push(6,0,8'hC0,1); push(5,0,8'hE0,0); push(4,0,8'h70,0); push(3,0,8'h38,0);
        push(2,0,8'h1C,0); push(1,0,8'h0E,0); push(0,0,8'h07,0);
        push(0,0,8'h03,0); push(0,0,8'h01,0);
        push(1,1,8'h03,1);
`else
        n1 = 15;
        push(1,1,8'h03,0); push(2,1,8'h07,0); push(3,1,8'h0E,0); push(4,1,8'h1C,0);
        push(5,1,8'h38,0); push(6,1,8'h70,0); push(7,1,8'hE0,0);
        push(6,0,8'hC0,1); push(5,0,8'hE0,0); push(4,0,8'h70,0); push(3,0,8'h38,0);
        push(2,0,8'h1C,0); push(1,0,8'h0E,0); push(0,0,8'h07,0);
        push(1,1,8'h03,1);
`endif
        rst_n = 1'b1; en = 1'b1; div = 24'd0; mode = KR_BOUNCE;
        repeat (n1) @(negedge clk);
        en = 1'b0;
        #1 check("sweep_consumed", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("idle_step", 32'(step), 32'd0);
        check("idle_pos",  32'(pos),  32'd1);

        // Prescaler period and enable freeze.
        push(2,1,8'h07,0); push(3,1,8'h0E,0); push(4,1,8'h1C,0);
        div = 24'd3; en = 1'b1;
        wait_step(c);
        check("first_period", 32'(c), 32'd4);
        wait_step(c);
        check("period", 32'(c), 32'd4);
        c = 0;
        repeat (2) begin @(negedge clk); c++; end
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            c++;
            check("frozen_led",  32'(led),  32'h0E);
            check("frozen_step", 32'(step), 32'd0);
        end
        en = 1'b1;
        wait_step(c2);
        check("stretched_period", 32'(c + c2), 32'd9);

        // HOLD, BOUNCE resume, ring modes, BOUNCE entered with ring direction.
        mode = KR_HOLD; div = 24'd0;
        push(4,1,8'h1C,0); push(4,1,8'h1C,0); push(4,1,8'h1C,0);
        repeat (3) @(negedge clk);
        mode = KR_BOUNCE;
        push(5,1,8'h38,0); push(6,1,8'h70,0);
        repeat (2) @(negedge clk);
        mode = KR_RING_UP;
        push(7,1,8'hE0,0); push(0,1,8'hC1,1); push(1,1,8'h83,0);
        repeat (3) @(negedge clk);
        mode = KR_RING_DOWN;
        push(0,0,8'h03,0); push(7,0,8'h83,1);
        repeat (2) @(negedge clk);
        mode = KR_BOUNCE;
        push(6,0,8'hC1,0); push(5,0,8'hE0,0);
        repeat (2) @(negedge clk);
        #1 check("modes_consumed", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset between edges while a step pulse is showing.
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        push(1,1,8'h03,0);
        rst_n = 1'b1; en = 1'b1; div = 24'd2; mode = KR_BOUNCE;
        wait_step(c);
        check("post_reset_first_step", 32'(c), 32'd3);

        // Run into the top end in BOUNCE.
        div = 24'd0;
        push(2,1,8'h07,0); push(3,1,8'h0E,0); push(4,1,8'h1C,0);
        push(5,1,8'h38,0); push(6,1,8'h70,0); push(7,1,8'hE0,0);
`ifdef KR_DWELL_EN
        push(7,1,8'hC0,0); push(7,1,8'h80,0); push(6,0,8'hC0,1);
`else
        push(6,0,8'hC0,1); push(5,0,8'hE0,0); push(4,0,8'h70,0);
`endif
        repeat (9) @(negedge clk);
        en = 1'b0;
        #1 check("end_consumed", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        summary();
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL global_timeout (t=%0t)", $time);
        n_err++;
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule
